lbist_misr_checker: RTL



---
 rtl/lbist_misr_checker.sv | 82 ++++++++
 1 files changed

// File: rtl/lbist_misr_checker.sv
// lbist_misr_checker: MISR response compactor framed by test window levels, with golden-signature verdict
module lbist_misr_checker #(
    parameter int              WIDTH  = 32,
    parameter logic [WIDTH-1:0] POLY  = 32'h04C11DB7,
    parameter logic [WIDTH-1:0] SEED  = '0,
    parameter logic [WIDTH-1:0] GOLDEN = '0,
    parameter int              CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             test_started,
    input  logic             test_finished,
    input  logic [WIDTH-1:0] resp_i,
    output logic [WIDTH-1:0] signature_o,
    output logic [CNT_W-1:0] sample_cnt_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COMPACT = 2'd1;
    localparam logic [1:0] CHECK   = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    logic [1:0]       st_q, st_d;
    logic [WIDTH-1:0] misr_q, misr_d, misr_nx;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pass_q, pass_d, busy_q, busy_d, done_q, done_d, upd;

    // Next-state: frame compaction on the window levels, one-cycle verdict, then freeze until reset
    always_comb begin
        st_d    = st_q;
        pass_d  = pass_q;
        upd     = 1'b0;
        misr_nx = {misr_q[WIDTH-2:0], 1'b0} ^ (misr_q[WIDTH-1] ? POLY : '0) ^ resp_i;
        case (st_q)
            IDLE: if (en && test_started) begin
                st_d = test_finished ? CHECK : COMPACT;
                upd  = !test_finished;
            end
            COMPACT: if (en) begin
                st_d = test_finished ? CHECK : COMPACT;
                upd  = !test_finished;
            end
            CHECK: begin
                pass_d = (misr_q == GOLDEN);
                st_d   = DONE;
            end
            default: ;
        endcase
        misr_d = upd ? misr_nx : misr_q;
        cnt_d  = (upd && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
        busy_d = (st_d == COMPACT) || (st_d == CHECK);
        done_d = (st_d == DONE);
    end

    // State and registered outputs; reset returns to IDLE with the seed signature
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q   <= IDLE;
            misr_q <= SEED;
            cnt_q  <= '0;
            pass_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            misr_q <= misr_d;
            cnt_q  <= cnt_d;
            pass_q <= pass_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign signature_o  = misr_q;
    assign sample_cnt_o = cnt_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign pass_o       = pass_q;
endmodule
